// File: rtl/mux_sel_pkg.sv
// Constants and FSM state type shared by the 4:1 mux select arbiter and its pick logic.
package mux_sel_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after i_start, wrapping around.
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [SEL_W-1:0] i_start,
    output logic             o_found,
    output logic [SEL_W-1:0] o_index
);
    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_found = 1'b0;
        o_index = i_start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (i_req[i_start + SEL_W'(i)]) begin
                o_found = 1'b1;
                o_index = i_start + SEL_W'(i);
            end
        end
    end
endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving a downstream 4:1 mux select, with bounded tenure length.
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t           r_state;
    logic [HW-1:0]    r_hold;
    logic [SEL_W-1:0] r_last;
    logic [SEL_W-1:0] w_start;
    logic             w_found;
    logic [SEL_W-1:0] w_index;
    logic             w_release;

    // last equals sel throughout a tenure, so one start index serves both states.
    assign w_start   = r_last + SEL_W'(1);
    assign w_release = !req[sel] || (r_hold == HOLD_LAST) || !en;

    rr_pick u_pick (
        .i_req   (req),
        .i_start (w_start),
        .o_found (w_found),
        .o_index (w_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            grant   <= '0;
            sel     <= '0;
            valid   <= 1'b0;
            r_hold  <= '0;
            r_last  <= SEL_W'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (en && w_found) begin
                        r_state <= GRANT;
                        grant   <= N_REQ'(1) << w_index;
                        sel     <= w_index;
                        valid   <= 1'b1;
                        r_hold  <= '0;
                        r_last  <= w_index;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        if (en && w_found) begin
                            grant  <= N_REQ'(1) << w_index;
                            sel    <= w_index;
                            r_hold <= '0;
                            r_last <= w_index;
                        end else begin
                            r_state <= IDLE;
                            grant   <= '0;
                            valid   <= 1'b0;
                            r_hold  <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning max consecutive grant cycles per tenure (legal 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  arbitration enable; 0 forces release and blocks new grants.
REQ-005 SHALL have port req  input  4  per-source request; bit i requests data_in[i] of the downstream 4:1 mux.
REQ-006 SHALL have port grant  output  4  one-hot registered grant, all-zero when idle.
REQ-007 SHALL have port sel  output  2  registered binary index of granted source; drives downstream mux sel.
REQ-008 SHALL have port valid  output  1  high while a grant is active; downstream mux out is meaningful only then.

Function
REQ-009 SHALL implement FSM states IDLE and GRANT.
REQ-010 SHALL, in IDLE with en=1 and req!=0, pick a winner by round-robin from (last+1) mod 4 upward with wrap, where last is the previously granted index.
REQ-011 SHALL present grant/sel/valid one cycle after the req edge that caused the pick (latency 1); no combinational path req->outputs.
REQ-012 SHALL keep grant == (1 << sel) whenever valid=1, and grant=0 whenever valid=0.
REQ-013 SHALL count cycles in GRANT with hold_cnt, reset to 0 at each new tenure start.
REQ-014 SHALL release when req[sel]=0, or hold_cnt==MAX_HOLD-1, or en=0; release-cycle inputs decide the next state.
REQ-015 SHALL, on release with en=1 and req!=0, start a new tenure the next cycle with no idle gap, searching from (sel+1) mod 4.
REQ-016 SHALL regrant the same source on timeout if it is the only requester (new tenure, hold_cnt=0).
REQ-017 SHALL, on release with no eligible request or en=0, enter IDLE: valid=0, grant=0, sel holds last value.
REQ-018 SHALL ignore requests arriving mid-tenure for other sources until release; they are considered at release.
REQ-019 SHALL treat simultaneous req drop of sel and timeout as a single release.
REQ-020 SHALL make last track sel at every tenure start.

Reset
REQ-021 SHALL, on rst_n low, asynchronously force state=IDLE, grant=4'b0000, sel=2'b00, valid=0, hold_cnt=0, last=2'b11 (so first search starts at source 0).
REQ-022 SHALL, on reset asserted mid-tenure, drop valid and grant in the same cycle without waiting for a clock edge.
REQ-023 SHALL begin arbitration on the first rising clk edge after rst_n deasserts.

Structure
REQ-024 SHALL take constants N_REQ=4, SEL_W=2 and the state typedef (IDLE, GRANT) from shared package mux_sel_pkg.
REQ-025 SHALL put round-robin pick logic in combinational sub-module rr_pick (inputs req, start index; outputs found, index).
REQ-026 SHALL size hold_cnt as $clog2(MAX_HOLD) bits and never wrap past MAX_HOLD-1.

Verification
REQ-027 SHALL cover reset: rst_n=0 with req=4'b1111 -> grant=0, valid=0, sel=0; release rst_n -> next edge grant=4'b0001, sel=0.
REQ-028 SHALL cover rotation: req=4'b1111 held, MAX_HOLD=8 -> sel sequence 0,1,2,3,0 each for 8 cycles, valid never drops.
REQ-029 SHALL cover early release: grant on source 2, drop req[2] after 3 cycles with req=4'b1001 -> next cycle sel=3, hold_cnt=0.
REQ-030 SHALL cover single-requester timeout: req=4'b0100 only -> sel=2 continuously, hold_cnt wraps 7->0, valid stays 1.
REQ-031 SHALL cover en deassert mid-tenure: en=0 during sel=1 -> next cycle valid=0, grant=0, sel=1; en=1 with req=4'b0010 -> sel=1 regranted after 1 cycle.
REQ-032 SHALL cover async reset mid-tenure: rst_n low between clock edges during sel=3 -> valid=0 immediately, and the bench checks grant one-hot/valid invariant every cycle.
